// File: rtl/axis_spm_scan_raster.sv
// Forward/backward raster scan generator feeding the SPM control stage xs/ys inputs.
// Optional SCAN_PAUSE_EN adds a pause input that freezes the scan in place.
module axis_spm_scan_raster #(
    parameter int WIDTH = 32,
    parameter int NBITS = 16,
    parameter int DBITS = 16
) (
    input  logic             a_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
`ifdef SCAN_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [NBITS-1:0] nx,
    input  logic [NBITS-1:0] ny,
    input  logic [WIDTH-1:0] dx,
    input  logic [WIDTH-1:0] dy,
    input  logic [WIDTH-1:0] x_start,
    input  logic [WIDTH-1:0] y_start,
    input  logic [DBITS-1:0] dwell,
    output logic [WIDTH-1:0] xs,
    output logic [WIDTH-1:0] ys,
    output logic             point_strobe,
    output logic             dir,
    output logic [NBITS-1:0] line_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, FWD, BWD, YSTEP, FIN} state_t;

    localparam logic signed [WIDTH:0] MAXV = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0] MINV = {2'b11, {(WIDTH-2){1'b0}}, 1'b1};

    state_t           state, next_state;
    logic             start_q;
    logic [NBITS-1:0] nx_r, ny_r, point;
    logic [WIDTH-1:0] dx_r, dy_r;
    logic [DBITS-1:0] dwell_r, dcnt;
    logic             start_edge, hold, last_dwell, last_point, last_line;
    logic signed [WIDTH:0] x_inc, x_dec, y_inc;

    // Symmetric saturation keeps the scan from ever folding to the opposite edge.
    function automatic logic [WIDTH-1:0] sat(input logic signed [WIDTH:0] s);
        if (s > MAXV)
            return MAXV[WIDTH-1:0];
        else if (s < MINV)
            return MINV[WIDTH-1:0];
        else
            return s[WIDTH-1:0];
    endfunction

    assign start_edge = start & ~start_q;
    assign last_dwell = (dcnt == dwell_r);
    assign last_point = (point == nx_r - NBITS'(1));
    assign last_line  = (line_idx == ny_r - NBITS'(1));
    assign x_inc = $signed({xs[WIDTH-1], xs}) + $signed({dx_r[WIDTH-1], dx_r});
    assign x_dec = $signed({xs[WIDTH-1], xs}) - $signed({dx_r[WIDTH-1], dx_r});
    assign y_inc = $signed({ys[WIDTH-1], ys}) + $signed({dy_r[WIDTH-1], dy_r});

`ifdef SCAN_PAUSE_EN
    assign hold = pause & ((state == FWD) | (state == BWD) | (state == YSTEP));
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        next_state   = state;
        busy         = (state != IDLE);
        done         = (state == FIN);
        dir          = (state == BWD);
        point_strobe = ((state == FWD) | (state == BWD)) & last_dwell & ~stop & ~hold;
        case (state)
            IDLE:  if (start_edge && !stop)
                       next_state = (nx == '0 || ny == '0) ? FIN : FWD;
            FWD:   if (stop) next_state = FIN;
                   else if (!hold && last_dwell && last_point) next_state = BWD;
            BWD:   if (stop) next_state = FIN;
                   else if (!hold && last_dwell && last_point) next_state = YSTEP;
            YSTEP: if (stop) next_state = FIN;
                   else if (!hold && last_dwell) next_state = last_line ? FIN : FWD;
            FIN:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge a_clk) begin
        if (reset) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            xs       <= '0;
            ys       <= '0;
            point    <= '0;
            line_idx <= '0;
            dcnt     <= '0;
            nx_r     <= '0;
            ny_r     <= '0;
            dx_r     <= '0;
            dy_r     <= '0;
            dwell_r  <= '0;
        end else begin
            state   <= next_state;
            start_q <= start;
            case (state)
                IDLE: if (start_edge && !stop) begin
                    nx_r    <= nx;
                    ny_r    <= ny;
                    dx_r    <= dx;
                    dy_r    <= dy;
                    dwell_r <= dwell;
                    if (nx != '0 && ny != '0) begin
                        xs       <= x_start;
                        ys       <= y_start;
                        point    <= '0;
                        line_idx <= '0;
                        dcnt     <= '0;
                    end
                end
                FWD, BWD: if (!stop && !hold) begin
                    if (last_dwell) begin
                        dcnt <= '0;
                        // The last forward point is revisited as the first backward point.
                        if (last_point)
                            point <= '0;
                        else begin
                            point <= point + NBITS'(1);
                            xs    <= (state == FWD) ? sat(x_inc) : sat(x_dec);
                        end
                    end else
                        dcnt <= dcnt + DBITS'(1);
                end
                YSTEP: if (!stop && !hold) begin
                    if (last_dwell) begin
                        dcnt <= '0;
                        if (!last_line) begin
                            ys       <= sat(y_inc);
                            line_idx <= line_idx + NBITS'(1);
                        end
                    end else
                        dcnt <= dcnt + DBITS'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_spm_scan_raster.sv
// Scoreboard bench for axis_spm_scan_raster: stimulus pushes expected strobes/done
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_axis_spm_scan_raster;

    logic        a_clk = 1'b0;
    logic        reset, start, stop;
`ifdef SCAN_PAUSE_EN
    logic        pause = 1'b0;
`endif
    logic [15:0] nx, ny, dwell;
    logic [31:0] dx, dy, x_start, y_start;
    logic [31:0] xs, ys;
    logic        point_strobe, dir, busy, done;
    logic [15:0] line_idx;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        d;
        logic [15:0] l;
    } strobe_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
    } done_t;

    strobe_t exp_q[$];
    done_t   done_q[$];
    int      checks = 0;
    int      fails = 0;
    int      strobe_cnt = 0;
    int      snap;

    axis_spm_scan_raster dut (
        .a_clk(a_clk), .reset(reset), .start(start), .stop(stop),
`ifdef SCAN_PAUSE_EN
        .pause(pause),
`endif
        .nx(nx), .ny(ny), .dx(dx), .dy(dy), .x_start(x_start), .y_start(y_start),
        .dwell(dwell), .xs(xs), .ys(ys), .point_strobe(point_strobe), .dir(dir),
        .line_idx(line_idx), .busy(busy), .done(done)
    );

    always #5 a_clk = ~a_clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge a_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] n_x, input logic [15:0] n_y, input logic [31:0] d_x,
                                 input logic [31:0] d_y, input logic [31:0] x0, input logic [31:0] y0,
                                 input logic [15:0] dw);
        nx = n_x; ny = n_y; dx = d_x; dy = d_y; x_start = x0; y_start = y0; dwell = dw;
    endtask

    task automatic pushStrobe(input logic [31:0] x, input logic [31:0] y, input logic d, input logic [15:0] l);
        strobe_t s;
        s.x = x; s.y = y; s.d = d; s.l = l;
        exp_q.push_back(s);
    endtask

    task automatic pushDone(input logic [31:0] x, input logic [31:0] y);
        done_t e;
        e.x = x; e.y = y;
        done_q.push_back(e);
    endtask

    // Hand-derived raster for nx=3, ny=2, dx=10, dy=100, x_start=-10, y_start=0.
    task automatic pushBaseScan();
        int xseq[6] = '{-10, 0, 10, 10, 0, -10};
        for (int ln = 0; ln < 2; ln++)
            for (int i = 0; i < 6; i++)
                pushStrobe(32'(xseq[i]), 32'(ln * 100), (i >= 3), 16'(ln));
        pushDone(32'hFFFF_FFF6, 32'd100);
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        checkOutput("done_within_budget", {63'd0, done}, 64'd1);
        tick();
        checkOutput("busy_after_fin", {63'd0, busy}, 64'd0);
    endtask

    always @(negedge a_clk) begin
        if (!reset) begin
            if (point_strobe) begin
                strobe_t s;
                strobe_cnt++;
                if (exp_q.size() == 0)
                    checkOutput("unexpected_strobe", 64'd1, 64'd0);
                else begin
                    s = exp_q.pop_front();
                    checkOutput("strobe_xs", {32'd0, xs}, {32'd0, s.x});
                    checkOutput("strobe_ys", {32'd0, ys}, {32'd0, s.y});
                    checkOutput("strobe_dir", {63'd0, dir}, {63'd0, s.d});
                    checkOutput("strobe_line", {48'd0, line_idx}, {48'd0, s.l});
                end
            end
            if (done) begin
                done_t e;
                if (done_q.size() == 0)
                    checkOutput("unexpected_done", 64'd1, 64'd0);
                else begin
                    e = done_q.pop_front();
                    checkOutput("done_xs", {32'd0, xs}, {32'd0, e.x});
                    checkOutput("done_ys", {32'd0, ys}, {32'd0, e.y});
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        applyStimulus(16'd3, 16'd2, 32'd10, 32'd100, 32'hFFFF_FFF6, 32'd0, 16'd1);
        tick(); tick();
        reset = 1'b0;
        checkOutput("reset_xs", {32'd0, xs}, 64'd0);
        checkOutput("reset_ys", {32'd0, ys}, 64'd0);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_line", {48'd0, line_idx}, 64'd0);
        tick();

        // Basic raster; inputs are scrambled after the start edge.
        pushBaseScan();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("first_point_busy", {63'd0, busy}, 64'd1);
        checkOutput("first_point_xs", {32'd0, xs}, 64'h0000_0000_FFFF_FFF6);
        applyStimulus(16'd7, 16'd9, 32'd999, 32'd555, 32'd1234, 32'd4321, 16'd5);
        waitDone(100);

        // Zero-size scan: immediate FIN, positions untouched.
        applyStimulus(16'd0, 16'd5, 32'd10, 32'd100, 32'd77, 32'd88, 16'd1);
        pushDone(32'hFFFF_FFF6, 32'd100);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("empty_done", {63'd0, done}, 64'd1);
        checkOutput("empty_busy_fin", {63'd0, busy}, 64'd1);
        tick();
        checkOutput("empty_busy_after", {63'd0, busy}, 64'd0);
        checkOutput("empty_xs_held", {32'd0, xs}, 64'h0000_0000_FFFF_FFF6);

        // Stop and start edge together in IDLE: no scan.
        applyStimulus(16'd3, 16'd2, 32'd10, 32'd100, 32'd0, 32'd0, 16'd1);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checkOutput("stop_wins_busy", {63'd0, busy}, 64'd0);
        checkOutput("stop_wins_done", {63'd0, done}, 64'd0);
        tick();

        // Saturation at the positive rail.
        applyStimulus(16'd2, 16'd1, 32'h20, 32'd0, 32'h7FFF_FFF0, 32'd5, 16'd0);
        pushStrobe(32'h7FFF_FFF0, 32'd5, 1'b0, 16'd0);
        pushStrobe(32'h7FFF_FFFF, 32'd5, 1'b0, 16'd0);
        pushStrobe(32'h7FFF_FFFF, 32'd5, 1'b1, 16'd0);
        pushStrobe(32'h7FFF_FFDF, 32'd5, 1'b1, 16'd0);
        pushDone(32'h7FFF_FFDF, 32'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(50);

        // Stop during the second backward point of line 0.
        applyStimulus(16'd4, 16'd2, 32'd1, 32'd50, 32'd0, 32'd0, 16'd3);
        for (int i = 0; i < 4; i++) pushStrobe(32'(i), 32'd0, 1'b0, 16'd0);
        pushStrobe(32'd3, 32'd0, 1'b1, 16'd0);
        pushDone(32'd2, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (21) tick();
        checkOutput("pre_stop_xs", {32'd0, xs}, 64'd2);
        checkOutput("pre_stop_dir", {63'd0, dir}, 64'd1);
        snap = strobe_cnt;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("stop_done", {63'd0, done}, 64'd1);
        checkOutput("stop_xs_frozen", {32'd0, xs}, 64'd2);
        tick();
        checkOutput("stop_busy_low", {63'd0, busy}, 64'd0);
        repeat (5) tick();
        checkOutput("stop_no_more_strobes", 64'(strobe_cnt), 64'(snap));

        // Reset in the middle of FWD point 2, then a full rerun.
        applyStimulus(16'd3, 16'd2, 32'd10, 32'd100, 32'hFFFF_FFF6, 32'd0, 16'd1);
        pushStrobe(32'hFFFF_FFF6, 32'd0, 1'b0, 16'd0);
        pushStrobe(32'd0, 32'd0, 1'b0, 16'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        checkOutput("pre_reset_xs", {32'd0, xs}, 64'd10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_reset_xs", {32'd0, xs}, 64'd0);
        checkOutput("mid_reset_ys", {32'd0, ys}, 64'd0);
        checkOutput("mid_reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("mid_reset_line", {48'd0, line_idx}, 64'd0);
        checkOutput("mid_reset_queue", 64'(exp_q.size()), 64'd0);
        snap = strobe_cnt;
        pushBaseScan();
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(100);
        checkOutput("rerun_strobe_count", 64'(strobe_cnt - snap), 64'd12);

`ifdef SCAN_PAUSE_EN
        // Pause inside the dwell of a single-point scan stretches it to 8 cycles.
        applyStimulus(16'd1, 16'd1, 32'd1, 32'd0, 32'd7, 32'd3, 16'd2);
        pushStrobe(32'd7, 32'd3, 1'b0, 16'd0);
        pushStrobe(32'd7, 32'd3, 1'b1, 16'd0);
        pushDone(32'd7, 32'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        pause = 1'b1;
        snap = strobe_cnt;
        repeat (5) tick();
        pause = 1'b0;
        checkOutput("pause_no_strobe", 64'(strobe_cnt), 64'(snap));
        tick();
        checkOutput("pause_strobe_cycle", {63'd0, point_strobe}, 64'd1);
        waitDone(50);
`endif

        repeat (2) tick();
        checkOutput("strobe_queue_empty", 64'(exp_q.size()), 64'd0);
        checkOutput("done_queue_empty", 64'(done_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/axis_spm_scan_raster.md
Name: axis_spm_scan_raster

Overview:
- Raster scan vector generator; sits directly upstream of the SPM control stage and drives its xs/ys scan-component inputs (rotated relative coordinates about the scan centre).
- Produces a forward/backward line raster: nx points per pass, ny lines, programmable dwell per point.
- Emits a per-point strobe and line/pass status for the data-acquisition path.

Parameters:
- WIDTH, 32, scan coordinate width (signed).
- NBITS, 16, width of point/line counters and nx/ny.
- DBITS, 16, width of dwell counter.

Ports:
- a_clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  rising-edge request to begin scan (edge-detected internally)
- stop  in  1  level abort; scan returns to IDLE
- nx  in  NBITS  points per line pass
- ny  in  NBITS  number of lines
- dx  in  WIDTH  signed x increment per point
- dy  in  WIDTH  signed y increment per line
- x_start  in  WIDTH  signed x of first point
- y_start  in  WIDTH  signed y of first line
- dwell  in  DBITS  clock cycles per point, minus 1 (0 = 1 cycle)
- xs  out  WIDTH  scan x component
- ys  out  WIDTH  scan y component
- point_strobe  out  1  one-cycle pulse at the last dwell cycle of each FWD/BWD point
- dir  out  1  0 = forward pass, 1 = backward pass
- line_idx  out  NBITS  current line index
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on scan completion or abort

Behaviour:
- Reset: xs=0, ys=0, point_strobe=0, dir=0, line_idx=0, busy=0, done=0, state IDLE; abandons any scan in progress on the cycle it is sampled.
- nx, ny, dx, dy, x_start, y_start and dwell are latched on the start edge; later changes have no effect on the running scan.
- States: IDLE, FWD, BWD, YSTEP, FIN.
- IDLE -> start edge:
  - nx==0 or ny==0: go to FIN (no motion).
  - Otherwise: on the next cycle xs=x_start, ys=y_start, point=0, line=0, state FWD.
- FWD: hold each point for dwell+1 cycles; on the final cycle assert point_strobe.
  - If point<nx-1: xs+=dx on the next cycle, point+=1.
  - Else: dir=1, point=0, state BWD; xs unchanged, so the turnaround point is revisited.
- BWD: same dwell and strobe rule, xs-=dx per step; after nx points go to YSTEP, dir=0.
- YSTEP: one dwell period, no strobe.
  - If line<ny-1: ys+=dy, xs held (equals x_start), line+=1, state FWD.
  - Else: state FIN.
- FIN: done=1 for exactly one cycle, then IDLE. xs/ys hold their last values.
- stop high in any non-IDLE state: next state FIN (done pulse); positions hold; in-flight strobe is suppressed.
- start edge while busy: ignored.
- stop and start edge in the same IDLE cycle: stop wins, scan is not started.
- Arithmetic: xs/ys updates are signed WIDTH+1 sums, saturated to +(2^(WIDTH-1)-1) / -(2^(WIDTH-1)-1); no wrap.
- Latency: xs/ys are registered; first point is valid 1 cycle after the start edge. busy rises in the same cycle as the first valid xs.
- Point count per line is exactly 2*nx strobes. Total strobes = 2*nx*ny.

Optional Feature:
- Macro: SCAN_PAUSE_EN.
- Defined: adds input pause (1 bit).
  - While pause=1 in FWD/BWD/YSTEP: dwell counter, point/line counters and positions freeze; point_strobe is held 0.
  - The strobe fires once when pause drops, if the freeze occurred on the final dwell cycle.
  - stop overrides pause.
- Undefined: no pause port; behaviour as above.

Test Plan:
- nx=3, ny=2, dx=10, dy=100, x_start=-10, y_start=0, dwell=1, start pulse -> xs sequence per 2-cycle point: -10,0,10,10,0,-10; ys 0 then 100 after YSTEP; 12 strobes total; done 1 cycle; final xs=-10, ys=100.
- nx=0, ny=5, start -> no strobes, xs/ys unchanged, done pulses 1 cycle after start edge, busy low throughout except FIN cycle.
- x_start=0x7FFFFFF0, dx=0x20, nx=2 -> second point xs=0x7FFFFFFF (saturated, no wrap); backward step gives 0x7FFFFFDF.
- Stop asserted mid-BWD of line 0 (nx=4, dwell=3) -> no further strobes, done next cycle, xs/ys frozen at the values from the stop cycle, busy drops after FIN.
- Reset asserted during FWD point 2 -> next cycle xs=ys=0, busy=0, line_idx=0. A following start runs a full scan with correct strobe count 2*nx*ny.
- SCAN_PAUSE_EN: pause held 5 cycles mid-dwell (dwell=2) -> that point lasts 8 cycles, exactly one strobe, counters unchanged during pause.
